// File: rtl/rcn_pkg.sv
// rcn ring packet layout shared by the Avalon bridge, its reorder buffer and benches.
package rcn_pkg;

  localparam int unsigned RCN_W        = 69;
  localparam int unsigned RCN_VALID    = 68;
  localparam int unsigned RCN_PEND     = 67;
  localparam int unsigned RCN_WR       = 66;
  localparam int unsigned RCN_ID_HI    = 65;
  localparam int unsigned RCN_ID_LO    = 60;
  localparam int unsigned RCN_MASK_HI  = 59;
  localparam int unsigned RCN_MASK_LO  = 56;
  localparam int unsigned RCN_ADDR_HI  = 55;
  localparam int unsigned RCN_ADDR_LO  = 34;
  localparam int unsigned RCN_SEQ_HI   = 33;
  localparam int unsigned RCN_SEQ_LO   = 32;
  localparam int unsigned RCN_DATA_HI  = 31;

  typedef struct packed {
    logic        valid;
    logic        pending;
    logic        wr;
    logic [5:0]  id;
    logic [3:0]  mask;
    logic [21:0] addr;
    logic [1:0]  seq;
    logic [31:0] data;
  } rcn_pkt_t;

endpackage

// File: rtl/avalon2rcn_rob_if.sv
// Avalon-MM bus between a CPU/DMA master and the rcn bridge.
interface avalon2rcn_rob_if;
  logic        av_waitrequest;
  logic [21:0] av_address;
  logic        av_write;
  logic        av_read;
  logic [3:0]  av_byteenable;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata;
  logic        av_readdatavalid;

  modport master (
    input  av_waitrequest, av_readdata, av_readdatavalid,
    output av_address, av_write, av_read, av_byteenable, av_writedata
  );

  modport slave (
    output av_waitrequest, av_readdata, av_readdatavalid,
    input  av_address, av_write, av_read, av_byteenable, av_writedata
  );
endinterface

// File: rtl/rcn_rob.sv
// 4-entry read reorder buffer: tags allocated in order, filled in any order,
// drained in issue order at most one per cycle.
module rcn_rob #(
  parameter int unsigned DEPTH   = 4,
  parameter bit          REORDER = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc,
  input  logic        fill,
  input  logic [1:0]  seq,
  input  logic [31:0] fill_data,
  output logic [1:0]  tag,
  output logic        tag_busy_c,
  output logic        full_c,
  output logic        fill_ok_c,
  output logic        hold_c,
  output logic        drain_c,
  output logic [31:0] drain_data_c,
  output logic [2:0]  pending
);

  logic [3:0]  busy_q, busy_d, done_q, done_d;
  logic [31:0] data_q [4];
  logic [31:0] data_d [4];
  logic [1:0]  tag_q, tag_d, head_q, head_d;
  logic [2:0]  pend_q, pend_d;
  logic        seq_live;

  // A tag is live while issued and not yet answered; in strict mode only the head may fill.
  assign seq_live     = busy_q[seq] & ~done_q[seq];
  assign fill_ok_c    = seq_live & (REORDER | (seq == head_q));
  assign hold_c       = seq_live & ~fill_ok_c;
  assign tag_busy_c   = busy_q[tag_q];
  assign full_c       = (pend_q == 3'(DEPTH));
  assign drain_c      = done_q[head_q];
  assign drain_data_c = data_q[head_q];
  assign tag          = tag_q;
  assign pending      = pend_q;

  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    data_d = data_q;
    tag_d  = tag_q;
    head_d = head_q;
    pend_d = pend_q + 3'(alloc) - 3'(drain_c);
    if (alloc) begin
      busy_d[tag_q] = 1'b1;
      tag_d         = tag_q + 2'd1;
    end
    if (fill) begin
      done_d[seq] = 1'b1;
      data_d[seq] = fill_data;
    end
    if (drain_c) begin
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      head_d         = head_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      done_q <= '0;
      tag_q  <= '0;
      head_q <= '0;
      pend_q <= '0;
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      tag_q  <= tag_d;
      head_q <= head_d;
      pend_q <= pend_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/avalon2rcn_rob.sv
// Avalon-MM slave to rcn ring master: inserts requests into free ring slots,
// consumes its own responses, returns read data in issue order.
module avalon2rcn_rob
  import rcn_pkg::*;
#(
  parameter logic [5:0]  MASTER_ID = 6'h3F,
  parameter int unsigned RD_DEPTH  = 4,
  parameter int unsigned WR_DEPTH  = 4,
  parameter bit          REORDER   = 1'b1
) (
  input  logic             av_clk,
  input  logic             av_rst,
  avalon2rcn_rob_if.slave  av,
  input  logic [RCN_W-1:0] rcn_in,
  output logic [RCN_W-1:0] rcn_out,
  output logic             rsp_err,
  output logic [2:0]       rd_pending,
  output logic [2:0]       wr_pending
);

  logic [RCN_W-1:0] rin_q, rout_d, rout_q;
  logic             rsp_err_d, rsp_err_q;
  logic [3:0]       wr_busy_d, wr_busy_q;
  logic [1:0]       wr_tag_d, wr_tag_q;
  logic [2:0]       wr_pend_d, wr_pend_q;

  logic        rin_valid, rin_pend, rin_wr;
  logic [5:0]  rin_id;
  logic [1:0]  rin_seq, rd_tag;
  logic [31:0] rin_data;
  logic        my_resp, rd_acc, rd_hold, wr_acc, consumed, slot_free;
  logic        rd_stall, wr_stall, rd_issue, wr_issue;
  logic        rob_tag_busy, rob_full, rob_fill_ok, rob_hold;
  rcn_pkt_t    req;

  assign rin_valid = rin_q[RCN_VALID];
  assign rin_pend  = rin_q[RCN_PEND];
  assign rin_wr    = rin_q[RCN_WR];
  assign rin_id    = rin_q[RCN_ID_HI:RCN_ID_LO];
  assign rin_seq   = rin_q[RCN_SEQ_HI:RCN_SEQ_LO];
  assign rin_data  = rin_q[RCN_DATA_HI:0];

  rcn_rob #(.DEPTH(RD_DEPTH), .REORDER(REORDER)) u_rob (
    .clk          (av_clk),
    .rst          (av_rst),
    .alloc        (rd_issue),
    .fill         (rd_acc),
    .seq          (rin_seq),
    .fill_data    (rin_data),
    .tag          (rd_tag),
    .tag_busy_c   (rob_tag_busy),
    .full_c       (rob_full),
    .fill_ok_c    (rob_fill_ok),
    .hold_c       (rob_hold),
    .drain_c      (av.av_readdatavalid),
    .drain_data_c (av.av_readdata),
    .pending      (rd_pending)
  );

  // Response classification; a held (non-head, strict mode) read stays on the ring.
  assign my_resp   = rin_valid & ~rin_pend & (rin_id == MASTER_ID);
  assign rd_acc    = my_resp & ~rin_wr & rob_fill_ok;
  assign rd_hold   = my_resp & ~rin_wr & rob_hold;
  assign wr_acc    = my_resp & rin_wr & wr_busy_q[rin_seq];
  assign consumed  = my_resp & ~rd_hold;
  assign slot_free = ~rin_valid | consumed;

  assign rd_stall = ~slot_free | rob_full | rob_tag_busy;
  assign wr_stall = ~slot_free | (wr_pend_q == 3'(WR_DEPTH)) | wr_busy_q[wr_tag_q];
  assign wr_issue = av.av_write & ~wr_stall;
  assign rd_issue = av.av_read & ~av.av_write & ~rd_stall;
  assign av.av_waitrequest = av.av_write ? wr_stall : (av.av_read & rd_stall);

  always_comb begin
    req.valid   = 1'b1;
    req.pending = 1'b1;
    req.wr      = wr_issue;
    req.id      = MASTER_ID;
    req.mask    = av.av_byteenable;
    req.addr    = av.av_address;
    req.seq     = wr_issue ? wr_tag_q : rd_tag;
    req.data    = wr_issue ? av.av_writedata : 32'h0;
  end

  always_comb begin
    rout_d    = rin_q;
    rsp_err_d = my_resp & ~rd_acc & ~wr_acc & ~rd_hold;
    wr_busy_d = wr_busy_q;
    wr_tag_d  = wr_tag_q + 2'(wr_issue);
    wr_pend_d = wr_pend_q + 3'(wr_issue) - 3'(wr_acc);
    if (consumed) rout_d = '0;
    if (wr_issue | rd_issue) rout_d = req;
    if (wr_acc) wr_busy_d[rin_seq] = 1'b0;
    if (wr_issue) wr_busy_d[wr_tag_q] = 1'b1;
  end

  always_ff @(posedge av_clk or posedge av_rst) begin
    if (av_rst) begin
      rin_q     <= '0;
      rout_q    <= '0;
      rsp_err_q <= 1'b0;
      wr_busy_q <= '0;
      wr_tag_q  <= '0;
      wr_pend_q <= '0;
    end else begin
      rin_q     <= rcn_in;
      rout_q    <= rout_d;
      rsp_err_q <= rsp_err_d;
      wr_busy_q <= wr_busy_d;
      wr_tag_q  <= wr_tag_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  assign rcn_out    = rout_q;
  assign rsp_err    = rsp_err_q;
  assign wr_pending = wr_pend_q;

endmodule

// File: tb/tb_avalon2rcn_rob.sv
// Directed bench: dut_a reorders with WR_DEPTH=2, dut_b is strict in-order.
module tb_avalon2rcn_rob;
  import rcn_pkg::*;

  logic av_clk = 1'b0;
  logic av_rst;
  always #5 av_clk = ~av_clk;

  avalon2rcn_rob_if ifa ();
  avalon2rcn_rob_if ifb ();
  logic [RCN_W-1:0] rcn_in_a, rcn_out_a, rcn_in_b, rcn_out_b;
  logic             rsp_err_a, rsp_err_b;
  logic [2:0]       rdp_a, wrp_a, rdp_b, wrp_b;

  avalon2rcn_rob #(.MASTER_ID(6'h3F), .RD_DEPTH(4), .WR_DEPTH(2), .REORDER(1'b1)) dut_a (
    .av_clk(av_clk), .av_rst(av_rst), .av(ifa), .rcn_in(rcn_in_a), .rcn_out(rcn_out_a),
    .rsp_err(rsp_err_a), .rd_pending(rdp_a), .wr_pending(wrp_a));

  avalon2rcn_rob #(.MASTER_ID(6'h3F), .RD_DEPTH(4), .WR_DEPTH(4), .REORDER(1'b0)) dut_b (
    .av_clk(av_clk), .av_rst(av_rst), .av(ifb), .rcn_in(rcn_in_b), .rcn_out(rcn_out_b),
    .rsp_err(rsp_err_b), .rd_pending(rdp_b), .wr_pending(wrp_b));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [68:0] pkt(input logic wr, input logic pend, input logic [5:0] id,
                                      input logic [3:0] mask, input logic [21:0] addr,
                                      input logic [1:0] seq, input logic [31:0] d);
    rcn_pkt_t p;
    p.valid = 1'b1; p.pending = pend; p.wr = wr; p.id = id;
    p.mask = mask; p.addr = addr; p.seq = seq; p.data = d;
    return p;
  endfunction

  function automatic logic [68:0] rsp(input logic wr, input logic [1:0] seq, input logic [31:0] d);
    return pkt(wr, 1'b0, 6'h3F, 4'h0, 22'h0, seq, d);
  endfunction

  task automatic cyc();
    @(posedge av_clk);
    #2;
  endtask

  task automatic do_reset();
    ifa.av_read = 0; ifa.av_write = 0; ifa.av_address = '0; ifa.av_byteenable = 4'hF; ifa.av_writedata = '0;
    ifb.av_read = 0; ifb.av_write = 0; ifb.av_address = '0; ifb.av_byteenable = 4'hF; ifb.av_writedata = '0;
    rcn_in_a = '0; rcn_in_b = '0;
    av_rst = 1'b1;
    cyc();
    av_rst = 1'b0;
    cyc();
  endtask

  logic [68:0] tin [11];
  logic [68:0] tout [11];
  logic        tv [11];
  logic [31:0] td [11];
  logic [68:0] fpkt;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    av_rst = 1'b1;
    #12;
    do_reset();

    // Reset state
    check("rst_wait",   ifa.av_waitrequest, 0);
    check("rst_rdp",    rdp_a, 0);
    check("rst_wrp",    wrp_a, 0);
    check("rst_rdv",    ifa.av_readdatavalid, 0);
    check("rst_err",    rsp_err_a, 0);
    check("rst_out",    rcn_out_a, 0);

    // Single read, in-order return
    ifa.av_read = 1; ifa.av_address = 22'h10;
    #1 check("t1_wait", ifa.av_waitrequest, 0);
    cyc();
    ifa.av_read = 0;
    check("t1_req", rcn_out_a, pkt(0, 1, 6'h3F, 4'hF, 22'h10, 2'd0, 32'h0));
    check("t1_rdp1", rdp_a, 1);
    cyc(); cyc();
    rcn_in_a = rsp(0, 2'd0, 32'hDEADBEEF);
    cyc();
    rcn_in_a = '0;
    check("t1_rdv_early", ifa.av_readdatavalid, 0);
    cyc();
    check("t1_rdv", ifa.av_readdatavalid, 1);
    check("t1_data", ifa.av_readdata, 32'hDEADBEEF);
    check("t1_consumed", rcn_out_a, 0);
    cyc();
    check("t1_rdv_off", ifa.av_readdatavalid, 0);
    check("t1_rdp0", rdp_a, 0);

    // Four reads answered 3,1,0,2 with reordering
    do_reset();
    ifa.av_read = 1;
    for (int i = 0; i < 4; i++) begin
      ifa.av_address = 22'(i * 4);
      cyc();
    end
    ifa.av_address = 22'h100;
    #1 check("t2_full_wait", ifa.av_waitrequest, 1);
    check("t2_rdp4", rdp_a, 4);
    rcn_in_a = rsp(0, 2'd3, 32'hA0000003); cyc();
    check("t2_wait_r3", ifa.av_waitrequest, 1);
    rcn_in_a = rsp(0, 2'd1, 32'hA0000001); cyc();
    check("t2_rm_r3", rcn_out_a, 0);
    rcn_in_a = rsp(0, 2'd0, 32'hA0000000); cyc();
    check("t2_rdv_hold", ifa.av_readdatavalid, 0);
    rcn_in_a = rsp(0, 2'd2, 32'hA0000002); cyc();
    check("t2_rdv0", ifa.av_readdatavalid, 1);
    check("t2_d0", ifa.av_readdata, 32'hA0000000);
    check("t2_wait_head", ifa.av_waitrequest, 1);
    rcn_in_a = '0; cyc();
    check("t2_d1", ifa.av_readdata, 32'hA0000001);
    check("t2_wait_free", ifa.av_waitrequest, 0);
    cyc();
    ifa.av_read = 0;
    check("t2_req5", rcn_out_a, pkt(0, 1, 6'h3F, 4'hF, 22'h100, 2'd0, 32'h0));
    check("t2_d2", ifa.av_readdata, 32'hA0000002);
    check("t2_rdp3", rdp_a, 3);
    cyc();
    check("t2_d3", ifa.av_readdata, 32'hA0000003);
    check("t2_rdv3", ifa.av_readdatavalid, 1);
    cyc();
    check("t2_rdv_end", ifa.av_readdatavalid, 0);
    check("t2_rdp1", rdp_a, 1);

    // Strict in-order: out-of-order responses recirculate until they reach head
    do_reset();
    ifb.av_read = 1;
    for (int i = 0; i < 4; i++) begin
      ifb.av_address = 22'(i * 4);
      cyc();
    end
    ifb.av_read = 0;
    tin[0] = rsp(0, 2'd3, 32'hB3); tin[1] = rsp(0, 2'd1, 32'hB1); tin[2] = rsp(0, 2'd0, 32'hB0);
    tin[3] = rsp(0, 2'd2, 32'hB2); tin[4] = rsp(0, 2'd1, 32'hB1); tin[5] = '0;
    tin[6] = rsp(0, 2'd2, 32'hB2); tin[7] = '0; tin[8] = rsp(0, 2'd3, 32'hB3); tin[9] = '0; tin[10] = '0;
    for (int t = 0; t < 11; t++) begin
      tout[t] = '0; tv[t] = 1'b0; td[t] = '0;
    end
    tout[1] = tin[0]; tout[2] = tin[1]; tout[4] = tin[3];
    tv[3] = 1; td[3] = 32'hB0; tv[5] = 1; td[5] = 32'hB1;
    tv[7] = 1; td[7] = 32'hB2; tv[9] = 1; td[9] = 32'hB3;
    for (int t = 0; t < 11; t++) begin
      rcn_in_b = tin[t];
      cyc();
      check($sformatf("t3_out%0d", t), rcn_out_b, tout[t]);
      check($sformatf("t3_rdv%0d", t), ifb.av_readdatavalid, tv[t]);
      if (tv[t]) check($sformatf("t3_data%0d", t), ifb.av_readdata, td[t]);
    end
    check("t3_rdp0", rdp_b, 0);

    // Writes against WR_DEPTH=2
    do_reset();
    ifa.av_write = 1;
    ifa.av_address = 22'h20; ifa.av_writedata = 32'h10000000; cyc();
    ifa.av_address = 22'h21; ifa.av_writedata = 32'h10000001; cyc();
    ifa.av_address = 22'h22; ifa.av_writedata = 32'h10000002;
    #1 check("t4_wait_full", ifa.av_waitrequest, 1);
    check("t4_wrp2", wrp_a, 2);
    cyc();
    check("t4_wait_still", ifa.av_waitrequest, 1);
    rcn_in_a = rsp(1, 2'd0, 32'h0); cyc();
    check("t4_wait_rsp", ifa.av_waitrequest, 1);
    rcn_in_a = '0; cyc();
    check("t4_wrp1", wrp_a, 1);
    check("t4_wait_free", ifa.av_waitrequest, 0);
    cyc();
    check("t4_req2", rcn_out_a, pkt(1, 1, 6'h3F, 4'hF, 22'h22, 2'd2, 32'h10000002));
    check("t4_wrp2b", wrp_a, 2);
    ifa.av_address = 22'h23; ifa.av_writedata = 32'h10000003;
    #1 check("t4_wait_w3", ifa.av_waitrequest, 1);
    rcn_in_a = rsp(1, 2'd1, 32'h0); cyc();
    rcn_in_a = '0; cyc();
    check("t4_wrp1b", wrp_a, 1);
    cyc();
    ifa.av_write = 0;
    check("t4_wrp2c", wrp_a, 2);
    rcn_in_a = rsp(1, 2'd2, 32'h0); cyc();
    rcn_in_a = rsp(1, 2'd3, 32'h0); cyc();
    rcn_in_a = '0;
    check("t4_wrp1c", wrp_a, 1);
    cyc();
    check("t4_wrp0", wrp_a, 0);
    check("t4_err", rsp_err_a, 0);

    // Foreign traffic blocks insertion; own response frees the slot
    do_reset();
    fpkt = pkt(0, 1, 6'h05, 4'h1, 22'h123, 2'd1, 32'h5555AAAA);
    ifa.av_read = 1; ifa.av_address = 22'h40; cyc();
    ifa.av_read = 0; rcn_in_a = fpkt; cyc();
    ifa.av_read = 1; ifa.av_address = 22'h41;
    #1 check("t5_wait_foreign", ifa.av_waitrequest, 1);
    rcn_in_a = rsp(0, 2'd0, 32'hC0FFEE00); cyc();
    check("t5_fwd", rcn_out_a, fpkt);
    check("t5_wait_slot", ifa.av_waitrequest, 0);
    rcn_in_a = '0; cyc();
    ifa.av_read = 0;
    check("t5_insert", rcn_out_a, pkt(0, 1, 6'h3F, 4'hF, 22'h41, 2'd1, 32'h0));
    check("t5_rdp2", rdp_a, 2);
    check("t5_data", ifa.av_readdata, 32'hC0FFEE00);

    // Unexpected response, then reset with reads outstanding
    do_reset();
    rcn_in_a = rsp(0, 2'd2, 32'h12345678); cyc();
    rcn_in_a = '0; cyc();
    check("t6_err", rsp_err_a, 1);
    check("t6_removed", rcn_out_a, 0);
    cyc();
    check("t6_err_pulse", rsp_err_a, 0);
    ifa.av_read = 1; ifa.av_address = 22'h50; cyc(); cyc();
    ifa.av_read = 0;
    check("t6_rdp2", rdp_a, 2);
    av_rst = 1'b1;
    #1 check("t6_rst_rdp", rdp_a, 0);
    check("t6_rst_out", rcn_out_a, 0);
    cyc();
    av_rst = 1'b0;
    rcn_in_a = rsp(0, 2'd0, 32'h0BADF00D); cyc();
    rcn_in_a = '0; cyc();
    check("t6_late_err", rsp_err_a, 1);
    check("t6_late_rdv", ifa.av_readdatavalid, 0);
    check("t6_late_out", rcn_out_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
